// File: rtl/fifo_fwft_ctrl_pkg.sv
// Shared sizing helpers for the first-word-fall-through FIFO controller.
// Widths are derived from the DEPTH parameter of the instantiating module.
package fifo_fwft_ctrl_pkg;

    localparam int BUF_ENTRIES = 2;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Level counts RAM words plus the in-flight read plus the output buffer.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 2;
    endfunction

endpackage

// File: rtl/fifo_fwft_ctrl_if.sv
// Valid/ready write and read channels of the FWFT FIFO, plus its fill level.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface fifo_fwft_ctrl_if
    import fifo_fwft_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [lvl_w(DEPTH)-1:0]   level;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level
    );
endinterface

// File: rtl/dual_one_clock_wr_first.sv
// One-clock simple dual-port RAM with independent write and registered read ports.
// A read of the address written in the same cycle returns the previous contents.
module dual_one_clock_wr_first
    import fifo_fwft_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [addr_w(DEPTH)-1:0]   wa,
    input  logic [WIDTH-1:0]           wd,
    input  logic                       re,
    input  logic [addr_w(DEPTH)-1:0]   ra,
    output logic [WIDTH-1:0]           q
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) q <= mem[ra];
    end
endmodule

// File: rtl/fifo_fwft_ctrl.sv
// FWFT FIFO controller: RAM pointers and occupancy, read prefetch, and a 2-entry
// output skid buffer that hides the registered RAM read latency.
module fifo_fwft_ctrl
    import fifo_fwft_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    fifo_fwft_ctrl_if.slave bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = lvl_w(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    ram_cnt;
    logic [CW-1:0]    ram_cnt_nxt;
    logic             rdy;

    logic             wr_vld_p0;
    logic [AW-1:0]    wr_addr_p0;
    logic [WIDTH-1:0] wr_data_p0;

    logic             rd_vld_p1;
    logic [WIDTH-1:0] ram_q_p1;

    logic [1:0]       buf_cnt;
    logic [1:0]       buf_after_pop;
    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;

    logic             wr_acc;
    logic             fetch;
    logic             pop;

    // A pending write still counts in ram_cnt, but is not yet readable; when it is
    // the only word held it sits at rd_ptr, so one extra word is required.
    always_comb begin
        wr_acc        = bus.in_valid & rdy;
        pop           = (buf_cnt != 2'd0) & bus.out_ready;
        buf_after_pop = buf_cnt - {1'b0, pop};
        fetch         = (ram_cnt > {{AW{1'b0}}, wr_vld_p0})
                        && ((buf_after_pop + {1'b0, rd_vld_p1}) < 2'(BUF_ENTRIES));
        ram_cnt_nxt   = ram_cnt + CW'(wr_acc) - CW'(fetch);
    end

    // ---- p0: write port register in front of the RAM ----
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            wr_addr_p0 <= wr_ptr;
            wr_data_p0 <= bus.in_data;
        end
    end

    dual_one_clock_wr_first #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk (clk),
        .we  (wr_vld_p0),
        .wa  (wr_addr_p0),
        .wd  (wr_data_p0),
        .re  (fetch),
        .ra  (rd_ptr),
        .q   (ram_q_p1)
    );

    // ---- p1: RAM q captured into the output skid buffer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            rdy       <= 1'b0;
            wr_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
            buf_cnt   <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            rdy       <= 1'b1;
            wr_vld_p0 <= 1'b0;
            rd_vld_p1 <= 1'b0;
            buf_cnt   <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (fetch)  rd_ptr <= rd_ptr + AW'(1);
            ram_cnt   <= ram_cnt_nxt;
            rdy       <= (ram_cnt_nxt < CNT_FULL);
            wr_vld_p0 <= wr_acc;
            rd_vld_p1 <= fetch;
            // A word captured during a pop always lands behind the surviving entry.
            case ({rd_vld_p1, pop})
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b10: begin
                    if (buf_cnt == 2'd0) buf0 <= ram_q_p1;
                    else                 buf1 <= ram_q_p1;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= ram_q_p1;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= ram_q_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = (buf_cnt != 2'd0);
    assign bus.out_data  = buf0;
    assign bus.level     = LW'(ram_cnt) + LW'(rd_vld_p1) + LW'(buf_cnt);

endmodule

// File: tb/tb_fifo_fwft_ctrl.sv
// Randomised and directed bench for fifo_fwft_ctrl against a queue-based model:
// the FIFO is a list of words; level is its length, and the head is what must appear.
module tb_fifo_fwft_ctrl;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic clk;
    logic rst_n;
    logic clr;

    fifo_fwft_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_fwft_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] q[$];
    int          n_chk;
    int          n_err;
    int          n_acc;
    int          n_pop;
    logic        pop_now;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic tick(input logic iv, input logic [31:0] d, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        check("level", 32'(bus.level), 32'(q.size()));
        check("level_max", 32'(int'(bus.level) <= DEPTH + 2), 32'd1);
        if (q.size() == 0) check("no_spurious", 32'(bus.out_valid), 32'd0);
        else if (bus.out_valid) check("head", bus.out_data, q[0]);
        if (q.size() < DEPTH) check("in_ready", 32'(bus.in_ready), 32'd1);
        if (q.size() == DEPTH + 2) check("full_block", 32'(bus.in_ready), 32'd0);
        pop_now = 1'b0;
        if (clr) begin
            q.delete();
        end else begin
            if (bus.out_valid && ordy && q.size() > 0) begin
                void'(q.pop_front());
                n_pop++;
                pop_now = 1'b1;
            end
            if (iv && bus.in_ready) begin
                q.push_back(d);
                n_acc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() > 0; i++) tick(1'b0, 32'd0, 1'b1);
        check("drained", 32'(q.size()), 32'd0);
    endtask

    // Single write into an empty FIFO; out_valid must rise exactly 3 edges later.
    task automatic write_lat(input logic [31:0] d);
        tick(1'b1, d, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("latency", 32'(bus.out_valid), 32'(k == 3));
            if (k < 3) tick(1'b0, 32'd0, 1'b0);
        end
        check("lat_data", bus.out_data, d);
        check("lat_level", 32'(bus.level), 32'd1);
        tick(1'b0, 32'd0, 1'b1);
        repeat (4) tick(1'b0, 32'd0, 1'b1);
    endtask

    task automatic check_idle_state(input string tag, input logic exp_rdy);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_level"}, 32'(bus.level), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(exp_rdy));
        check({tag, "_out_data"}, bus.out_data, 32'd0);
    endtask

    // mode 0: random 50% valid/ready; mode 1: stall-then-trickle pattern
    task automatic run_traffic(input string tag, input int words, input int mode, input int max_cyc);
        int fed;
        int got;
        int a0;
        logic iv;
        logic ordy;
        fed = 0;
        got = 0;
        for (int c = 0; c < max_cyc && got < words; c++) begin
            if (mode == 0) begin
                iv   = (fed < words) && ($urandom_range(1, 0) == 1);
                ordy = ($urandom_range(1, 0) == 1);
            end else begin
                iv   = (fed < words) && (c % 3 != 2);
                ordy = (c >= 24) && (c % 4 != 0);
            end
            a0 = n_acc;
            tick(iv, (mode == 0) ? $urandom : 32'hC0DE_0000 + 32'(fed), ordy);
            if (n_acc != a0) fed++;
            if (pop_now) got++;
        end
        check({tag, "_count"}, 32'(got), 32'(words));
    endtask

    // variant 0: clr while full; 1: clr with a fetch in flight; 2: reset with a fetch in flight
    task automatic flush_probe(input int variant);
        for (int i = 0; i < 22; i++) tick(1'b1, 32'hBEEF_0000 + 32'(i), 1'b0);
        check("pre_flush_full", 32'(bus.level), 32'(DEPTH + 2));
        if (variant != 0) tick(1'b0, 32'd0, 1'b1);
        if (variant == 2) begin
            #2 rst_n = 1'b0;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b0;
            #1 check_idle_state("in_reset", 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            q.delete();
            @(negedge clk);
            check_idle_state("after_rst", 1'b1);
        end else begin
            clr = 1'b1;
            tick(1'b1, 32'hDEAD_DEAD, 1'b1);
            clr = 1'b0;
            check_idle_state("after_clr", 1'b1);
        end
        write_lat(32'h0000_1234);
    endtask

    initial begin
        int a0;
        int p0;
        int first;
        int last;
        int nxt;
        n_chk = 0;
        n_err = 0;
        n_acc = 0;
        n_pop = 0;
        pop_now = 1'b0;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_state("reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy_after_release", 32'(bus.in_ready), 32'd1);

        // Single word latency
        write_lat(32'hA5A5_0001);

        // Fill with output stalled
        a0 = n_acc;
        for (int i = 0; i < 30; i++) tick(1'b1, 32'hF000_0000 + 32'(i), 1'b0);
        check("fill_count", 32'(n_acc - a0), 32'(DEPTH + 2));
        check("fill_in_ready", 32'(bus.in_ready), 32'd0);
        check("fill_level", 32'(bus.level), 32'(DEPTH + 2));
        drain();

        // Streaming at full rate
        p0 = n_pop;
        first = -1;
        last = -1;
        nxt = 0;
        for (int c = 0; c < 120; c++) begin
            a0 = n_acc;
            tick(nxt < 100, 32'(nxt), 1'b1);
            if (n_acc != a0) nxt++;
            if (pop_now) begin
                if (first < 0) first = c;
                last = c;
            end
        end
        check("stream_count", 32'(n_pop - p0), 32'd100);
        check("stream_first", 32'(first), 32'd4);
        check("stream_gapless", 32'(last - first + 1), 32'd100);

        run_traffic("random", 1000, 0, 20000);
        drain();
        run_traffic("wrap", 40, 1, 600);
        drain();

        for (int v = 0; v < 3; v++) flush_probe(v);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
